// File: rtl/mcpu_core_f2d_buffer.sv
// Fetch-to-decode instruction buffer: circular FIFO of {inst, pc} that presents head and
// head+1 words to decode and tracks the squashed immediate slot behind long-immediate ops.
module mcpu_core_f2d_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst,
  input  logic        f2b_valid,
  input  logic [31:0] f2b_inst,
  input  logic [31:0] f2b_pc,
  output logic        b2f_ready,
  output logic [31:0] b2d_inst,
  output logic [31:0] b2d_nextinst,
  output logic [31:0] b2d_pc,
  output logic        b2d_valid,
  output logic        b2d_next_valid,
  output logic        b2d_prev_long_imm,
  input  logic        d2b_advance,
  input  logic        d2b_long_imm,
  input  logic        ex2b_flush,
  output logic        b2d_accept
);

  // Handshakes: fetch->buffer transfers a word on a cycle where f2b_valid & b2f_ready
  // (and no flush); buffer->decode consumes the head on a cycle where b2d_accept is high.
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nx;
  logic [PTR_W:0]   count;
  logic             push;

  assign rd_ptr_nx      = rd_ptr + PTR_W'(1);
  assign b2f_ready      = (count != FULL);
  assign b2d_valid      = (count != '0);
  assign b2d_next_valid = (count > (PTR_W+1)'(1));
  assign push           = f2b_valid & b2f_ready & ~ex2b_flush;

  // A long-immediate op waits until its immediate word is buffered behind it.
  assign b2d_accept = d2b_advance & b2d_valid & ~ex2b_flush &
                      (~d2b_long_imm | b2d_next_valid | b2d_prev_long_imm);

  // Invalid slots read as zero so decode never sees stale words.
  assign b2d_inst     = b2d_valid      ? inst_mem[rd_ptr]    : 32'd0;
  assign b2d_pc       = b2d_valid      ? pc_mem[rd_ptr]      : 32'd0;
  assign b2d_nextinst = b2d_next_valid ? inst_mem[rd_ptr_nx] : 32'd0;

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst || ex2b_flush) begin
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
      b2d_prev_long_imm <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (b2d_accept) begin
        rd_ptr            <= rd_ptr_nx;
        // The immediate word itself never marks the slot behind it.
        b2d_prev_long_imm <= d2b_long_imm & ~b2d_prev_long_imm;
      end
      case ({push, b2d_accept})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity comes from count alone.
  always_ff @(posedge clkrst_core_clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= f2b_inst;
      pc_mem[wr_ptr]   <= f2b_pc;
    end
  end

endmodule

// File: tb/tb_mcpu_core_f2d_buffer.sv
// Bench for mcpu_core_f2d_buffer: directed scenarios plus randomized traffic checked
// against a queue-based model of the buffer contents and the long-immediate flag.
module tb_mcpu_core_f2d_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f2b_valid = 1'b0;
  logic [31:0] f2b_inst = '0;
  logic [31:0] f2b_pc = '0;
  logic        b2f_ready;
  logic [31:0] b2d_inst;
  logic [31:0] b2d_nextinst;
  logic [31:0] b2d_pc;
  logic        b2d_valid;
  logic        b2d_next_valid;
  logic        b2d_prev_long_imm;
  logic        d2b_advance = 1'b0;
  logic        d2b_long_imm = 1'b0;
  logic        ex2b_flush = 1'b0;
  logic        b2d_accept;

  int passed = 0;
  int total  = 0;

  // Model: buffered words as {inst, pc} in arrival order, plus the squash flag.
  logic [63:0] exp_q[$];
  bit          m_prev = 1'b0;

  mcpu_core_f2d_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clkrst_core_clk  (clk),
    .clkrst_core_rst  (rst),
    .f2b_valid        (f2b_valid),
    .f2b_inst         (f2b_inst),
    .f2b_pc           (f2b_pc),
    .b2f_ready        (b2f_ready),
    .b2d_inst         (b2d_inst),
    .b2d_nextinst     (b2d_nextinst),
    .b2d_pc           (b2d_pc),
    .b2d_valid        (b2d_valid),
    .b2d_next_valid   (b2d_next_valid),
    .b2d_prev_long_imm(b2d_prev_long_imm),
    .d2b_advance      (d2b_advance),
    .d2b_long_imm     (d2b_long_imm),
    .ex2b_flush       (ex2b_flush),
    .b2d_accept       (b2d_accept)
  );

  always #5 clk = ~clk;

  function automatic bit exp_acc();
    return d2b_advance && exp_q.size() >= 1 && !ex2b_flush &&
           (!d2b_long_imm || exp_q.size() >= 2 || m_prev);
  endfunction

  // {ready, valid, next_valid, prev_long_imm, accept, inst, nextinst, pc}
  function automatic logic [100:0] exp_out();
    logic [31:0] e_inst, e_next, e_pc;
    e_inst = (exp_q.size() >= 1) ? exp_q[0][63:32] : 32'd0;
    e_pc   = (exp_q.size() >= 1) ? exp_q[0][31:0]  : 32'd0;
    e_next = (exp_q.size() >= 2) ? exp_q[1][63:32] : 32'd0;
    return {exp_q.size() < DEPTH, exp_q.size() >= 1, exp_q.size() >= 2, m_prev,
            exp_acc(), e_inst, e_next, e_pc};
  endfunction

  function automatic logic [100:0] obs();
    return {b2f_ready, b2d_valid, b2d_next_valid, b2d_prev_long_imm, b2d_accept,
            b2d_inst, b2d_nextinst, b2d_pc};
  endfunction

  task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit adv, input bit li, input bit fl);
    f2b_valid    = v;
    f2b_inst     = inst;
    f2b_pc       = pc;
    d2b_advance  = adv;
    d2b_long_imm = li;
    ex2b_flush   = fl;
    #1;
  endtask

  // Advance one clock and apply the same cycle's effect to the model.
  task automatic tick();
    bit do_push, do_acc;
    do_push = f2b_valid && exp_q.size() < DEPTH && !ex2b_flush;
    do_acc  = exp_acc();
    @(posedge clk);
    if (rst || ex2b_flush) begin
      exp_q.delete();
      m_prev = 1'b0;
    end else begin
      if (do_acc) begin
        m_prev = d2b_long_imm && !m_prev;
        void'(exp_q.pop_front());
      end
      if (do_push) exp_q.push_back({f2b_inst, f2b_pc});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, $urandom, $urandom, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({b2f_ready, b2d_valid, b2d_next_valid, b2d_prev_long_imm} !== 4'b1000 ||
        {b2d_inst, b2d_nextinst, b2d_pc} !== 96'd0) begin
      $display("FAIL reset_state got=%h exp=ready1 others0", obs());
    end else passed++;
  endtask

  task automatic test_fill();
    logic [31:0] w[4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      drive(1'b1, w[i], 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
      total++;
      if (obs() !== exp_out()) $display("FAIL fill_c%0d got=%h exp=%h", i, obs(), exp_out());
      else passed++;
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    total++;
    if (b2f_ready !== 1'b0 || b2d_inst !== w[0] || b2d_nextinst !== w[1] || b2d_pc !== 32'h100)
      $display("FAIL fill_full got=%h exp_head=%h exp_next=%h", obs(), w[0], w[1]);
    else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] w[10];
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (i < 10) w[i] = $urandom;
      drive(i < 10, (i < 10) ? w[i] : 32'd0, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0);
      total++;
      if (obs() !== exp_out()) $display("FAIL stream_c%0d got=%h exp=%h", i, obs(), exp_out());
      else passed++;
      if (i >= 1) begin
        total++;
        if (b2d_accept !== 1'b1 || b2d_inst !== w[i-1] || b2d_next_valid !== 1'b0)
          $display("FAIL stream_order_c%0d got_acc=%b got_inst=%h exp_inst=%h", i, b2d_accept,
                   b2d_inst, w[i-1]);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_long_imm();
    logic [31:0] op, imm;
    op  = $urandom;
    imm = $urandom;
    do_reset();
    drive(1'b1, op, 32'h300, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(i == 3, imm, 32'h301, 1'b1, 1'b1, 1'b0);
      total++;
      if (b2d_accept !== 1'b0 || obs() !== exp_out())
        $display("FAIL limm_wait_c%0d got=%h exp=%h", i, obs(), exp_out());
      else passed++;
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    total++;
    if (b2d_accept !== 1'b1 || b2d_inst !== op || b2d_nextinst !== imm)
      $display("FAIL limm_accept got=%h exp_acc=1", obs());
    else passed++;
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    total++;
    if (b2d_prev_long_imm !== 1'b1 || b2d_accept !== 1'b1 || b2d_inst !== imm)
      $display("FAIL limm_squash got=%h exp_prev=1 exp_inst=%h", obs(), imm);
    else passed++;
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    total++;
    if (b2d_prev_long_imm !== 1'b0 || b2d_valid !== 1'b0)
      $display("FAIL limm_done got=%h exp_prev=0 exp_valid=0", obs());
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    // Long-imm held high throughout: the immediate words must still not set the flag.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      total++;
      if (b2d_accept !== 1'b1 || b2d_prev_long_imm !== 1'(k % 2) || obs() !== exp_out())
        $display("FAIL b2b_acc%0d got=%h exp=%h", k, obs(), exp_out());
      else passed++;
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    total++;
    if (b2d_prev_long_imm !== 1'b0 || b2d_valid !== 1'b0)
      $display("FAIL b2b_end got=%h exp_prev=0 exp_valid=0", obs());
    else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hdead_beef, 32'h5ff, 1'b1, 1'b1, 1'b1);
    total++;
    if (b2d_prev_long_imm !== 1'b1 || b2d_accept !== 1'b0 || b2d_next_valid !== 1'b1)
      $display("FAIL flush_pre got=%h exp_prev=1 exp_acc=0", obs());
    else passed++;
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({b2f_ready, b2d_valid, b2d_next_valid, b2d_prev_long_imm} !== 4'b1000 ||
        b2d_inst !== 32'd0)
      $display("FAIL flush_post got=%h exp=empty", obs());
    else passed++;
    tick();
    total++;
    if (b2d_valid !== 1'b0 || obs() !== exp_out())
      $display("FAIL flush_dropped got=%h exp=%h", obs(), exp_out());
    else passed++;
  endtask

  task automatic test_reset_midstream_random();
    int bad_acc;
    int bad_out;
    bad_acc = 0;
    bad_out = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, 32'h600 + 32'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    drive(1'b1, $urandom, 32'h6ff, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({b2f_ready, b2d_valid, b2d_next_valid, b2d_prev_long_imm} !== 4'b1000 ||
        {b2d_inst, b2d_nextinst, b2d_pc} !== 96'd0)
      $display("FAIL midrst got=%h exp=empty", obs());
    else passed++;
    for (int i = 0; i < 40 * DEPTH; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 32'h1000 + 32'(i), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
      if (obs() !== exp_out()) begin
        if (bad_out < 4) $display("FAIL rand_c%0d got=%h exp=%h", i, obs(), exp_out());
        bad_out++;
      end
      if (b2d_accept === 1'b1 && b2d_valid !== 1'b1) bad_acc++;
      tick();
    end
    total++;
    if (bad_out != 0) $display("FAIL rand_outputs got=%0d bad cycles exp=0", bad_out);
    else passed++;
    total++;
    if (bad_acc != 0) $display("FAIL rand_accept_empty got=%0d exp=0", bad_acc);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_long_imm();
    test_back_to_back();
    test_flush();
    test_reset_midstream_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
